// File: rtl/lcd_bus_arbiter.sv
// Arbitrates two character/command writers and a clear requester onto one
// HD44780-style panel bus, generating timed LCD_EN and LCD_RST pulses.
module lcd_bus_arbiter #(
  parameter int unsigned EN_HIGH_CYC = 2,
  parameter int unsigned EN_LOW_CYC  = 1,
  parameter int unsigned RST_CYC     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic       clr_req,
  output logic       ack0,
  output logic       ack1,
  output logic       clr_ack,
  output logic       busy,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RST
);

  typedef enum logic [1:0] {IDLE, EN_HI, EN_LO, CLR} state_t;

  localparam logic [7:0] EN_HI_LOAD = 8'(EN_HIGH_CYC - 1);
  localparam logic [7:0] EN_LO_LOAD = 8'(EN_LOW_CYC - 1);
  localparam logic [7:0] CLR_LOAD   = 8'(RST_CYC - 1);

  state_t     state;
  logic [7:0] phase_cnt;
  logic       last_grant;  // requester granted most recently
  logic       pick1;

  // Requester 1 wins when alone, or when both ask and 0 was served last.
  always_comb begin
    pick1 = 1'b0;
    if (req1 && (!req0 || !last_grant))
      pick1 = 1'b1;
  end

  // NOTE: every register here is updated with non-blocking assignments so all
  // outputs change together on the edge and never depend on evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= 8'd0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      clr_ack    <= 1'b0;
      busy       <= 1'b0;
      LCD_DATA   <= 8'h00;
      LCD_RW     <= 1'b1;
      LCD_EN     <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_RST    <= 1'b0;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      clr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state     <= CLR;
            phase_cnt <= CLR_LOAD;
            clr_ack   <= 1'b1;
            busy      <= 1'b1;
            LCD_RST   <= 1'b1;
          end else if (req0 || req1) begin
            state      <= EN_HI;
            phase_cnt  <= EN_HI_LOAD;
            last_grant <= pick1;
            ack0       <= !pick1;
            ack1       <= pick1;
            busy       <= 1'b1;
            LCD_DATA   <= pick1 ? data1 : data0;
            LCD_RS     <= pick1 ? rs1 : rs0;
            LCD_RW     <= 1'b0;
            LCD_EN     <= 1'b1;
          end
        end
        EN_HI: begin
          if (phase_cnt == 8'd0) begin
            state     <= EN_LO;
            phase_cnt <= EN_LO_LOAD;
            LCD_EN    <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        EN_LO: begin
          if (phase_cnt == 8'd0) begin
            state  <= IDLE;
            busy   <= 1'b0;
            LCD_RW <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        CLR: begin
          if (phase_cnt == 8'd0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            LCD_RST <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          LCD_EN  <= 1'b0;
          LCD_RW  <= 1'b1;
          LCD_RST <= 1'b0;
        end
      endcase
    end
  end

endmodule
